chip_clk_gen: RTL and testbench

Multi-channel programmable clock generator, successor to the single fixed-ratio chip clock divider. Derives `N_CH` independent divided clocks from `clki`. Each channel's period and high time are loaded at run time through a valid/ready port and applied glitch-free at period boundaries. Each channel starts and stops cleanly, and an optional per-channel rising-edge strobe is provided. Sits between the 100 MHz system clock and the chip-side clock consumers.

---
 rtl/chip_clk_gen.sv | 178 +++++++++++++++++
 tb/tb_chip_clk_gen.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/chip_clk_gen.sv
// chip_clk_gen: multi-channel programmable clock generator.
//
// Derives N_CH independent divided clocks from clki. Each channel has its own
// counter, an active period/high-time pair and a shadow pair loaded through a
// valid/ready config port. Shadow values move to the active pair only at a
// period boundary (or immediately while the channel is idle), so a running
// output never glitches.
//
// Optional build macro: CHIP_CLK_TICK_EN
//   defined   -> tick_o carries a one-cycle strobe on every clk_o rising edge
//   undefined -> tick_o is tied low and no tick registers are built
//
// Ports
//   clki       in   system clock, all logic on its rising edge
//   rst        in   asynchronous active-high reset
//   clk_enb    in   synchronous global clear (forces every channel idle)
//   ch_en      in   [N_CH]   per-channel run request
//   cfg_valid  in   config request
//   cfg_ready  out  config accept (!pending of the addressed channel)
//   cfg_ch     in   [CH_W]   target channel (out of range: accepted, dropped)
//   cfg_div    in   [CNT_W]  period in clki cycles
//   cfg_high   in   [CNT_W]  high time in clki cycles
//   clk_o      out  [N_CH]   divided clocks, registered
//   tick_o     out  [N_CH]   rising-edge strobes, registered

// One output channel.
module chip_clk_ch #(
  parameter int CNT_W   = 26,
  parameter int DEF_DIV = 166667
) (
  input  logic             clki,
  input  logic             rst,
  input  logic             clk_enb,
  input  logic             en,
  input  logic             wr,
  input  logic [CNT_W-1:0] wdiv,
  input  logic [CNT_W-1:0] whigh,
  output logic             clk,
  output logic             tick,
  output logic             pending
);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [CNT_W-1:0] DEF_D = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEF_DIV / 2);

  logic [0:0]       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] div_a, high_a, div_p, high_p;
  logic [CNT_W-1:0] div_n, high_n;
  logic             clk_n, wrap, apply;

  assign wrap  = (state == ST_RUN) && (cnt == div_a - CNT_W'(1));
  // pending is registered, so a config accepted on a wrap edge is only seen
  // at the following boundary.
  assign apply = pending && (clk_enb || (state == ST_IDLE) || wrap);
  // Values that govern the cycle after this edge.
  assign div_n  = apply ? div_p  : div_a;
  assign high_n = apply ? high_p : high_a;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    clk_n   = clk;
    if (clk_enb) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
      clk_n   = 1'b0;
    end else if (state == ST_IDLE) begin
      cnt_n = '0;
      clk_n = 1'b0;
      if (en) begin
        state_n = ST_RUN;
        clk_n   = (high_n != '0);
      end
    end else if (wrap && !en) begin
      // en is only sampled at the wrap: the last period always completes
      state_n = ST_IDLE;
      cnt_n   = '0;
      clk_n   = 1'b0;
    end else begin
      cnt_n = wrap ? '0 : cnt + CNT_W'(1);
      clk_n = (cnt_n < high_n);
    end
  end

  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      clk     <= 1'b0;
      div_a   <= DEF_D;
      high_a  <= DEF_H;
      div_p   <= DEF_D;
      high_p  <= DEF_H;
      pending <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      clk   <= clk_n;
      // wr needs !pending and apply needs pending: never both at once
      if (wr) begin
        div_p   <= wdiv;
        high_p  <= whigh;
        pending <= 1'b1;
      end else if (apply) begin
        div_a   <= div_n;
        high_a  <= high_n;
        pending <= 1'b0;
      end
    end
  end

`ifdef CHIP_CLK_TICK_EN
  logic tick_q;
  always_ff @(posedge clki or posedge rst) begin
    if (rst) tick_q <= 1'b0;
    else     tick_q <= clk_n & ~clk;
  end
  assign tick = tick_q;
`else
  assign tick = 1'b0;
`endif
endmodule

module chip_clk_gen #(
  parameter  int N_CH    = 4,
  parameter  int CNT_W   = 26,
  parameter  int DEF_DIV = 166667,
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clki,
  input  logic             rst,
  input  logic             clk_enb,
  input  logic [N_CH-1:0]  ch_en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_high,
  output logic [N_CH-1:0]  clk_o,
  output logic [N_CH-1:0]  tick_o
);
  logic [N_CH-1:0]        pending;
  logic [(1<<CH_W)-1:0]   pend_x;
  logic [CNT_W-1:0]       div_c, high_c;
  logic                   acc;

  // Zero-padded so an out-of-range cfg_ch reads as not pending (ready=1).
  always_comb begin
    pend_x            = '0;
    pend_x[N_CH-1:0]  = pending;
  end

  assign cfg_ready = !pend_x[cfg_ch];
  assign acc       = cfg_valid && cfg_ready;

  // Clamp once at the port: period >= 2, high time <= period.
  always_comb begin
    div_c  = (cfg_div < CNT_W'(2)) ? CNT_W'(2) : cfg_div;
    high_c = (cfg_high >= div_c) ? div_c : cfg_high;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    chip_clk_ch #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) u_ch (
      .clki    (clki),
      .rst     (rst),
      .clk_enb (clk_enb),
      .en      (ch_en[i]),
      .wr      (acc && (cfg_ch == CH_W'(i))),
      .wdiv    (div_c),
      .whigh   (high_c),
      .clk     (clk_o[i]),
      .tick    (tick_o[i]),
      .pending (pending[i])
    );
  end
endmodule

// File: tb/tb_chip_clk_gen.sv
// Scoreboard bench for chip_clk_gen (N_CH=4, DEF_DIV=10).
// Expected per-cycle values of clk_o, tick_o and cfg_ready are queued with
// the cycle they belong to; a negedge monitor pops and compares them.
module tb_chip_clk_gen;
  localparam int N_CH  = 4;
  localparam int CNT_W = 26;
  localparam int CH_W  = 2;
`ifdef CHIP_CLK_TICK_EN
  localparam bit TICK = 1'b1;
`else
  localparam bit TICK = 1'b0;
`endif

  logic             clki = 1'b0;
  logic             rst = 1'b1;
  logic             clk_enb = 1'b0;
  logic [N_CH-1:0]  ch_en = '0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch = '0;
  logic [CNT_W-1:0] cfg_div = '0;
  logic [CNT_W-1:0] cfg_high = '0;
  logic [N_CH-1:0]  clk_o, tick_o;

  chip_clk_gen #(.N_CH(N_CH), .CNT_W(CNT_W), .DEF_DIV(10)) dut (
    .clki(clki), .rst(rst), .clk_enb(clk_enb), .ch_en(ch_en),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_high(cfg_high), .clk_o(clk_o), .tick_o(tick_o)
  );

  always #5 clki = ~clki;

  int cyc = 0;
  always @(posedge clki) cyc <= cyc + 1;

  // kind: 0 = clk_o[ch], 1 = tick_o[ch], 2 = cfg_ready
  typedef struct {
    int cyc;
    int kind;
    int ch;
    bit val;
  } exp_t;
  exp_t sbq[$];
  int tests = 0;
  int fails = 0;

  task automatic push(input int c, input int k, input int ch, input bit v);
    exp_t e;
    e.cyc = c; e.kind = k; e.ch = ch; e.val = v;
    sbq.push_back(e);
  endtask

  // Periodic waveform starting at cnt=0 in cycle s; prev is clk_o before s.
  task automatic wave(input int ch, input int s, input int n, input int dv,
                      input int hi, input bit prev);
    bit c, p;
    p = prev;
    for (int k = 0; k < n; k++) begin
      c = ((k % dv) < hi);
      push(s + k, 0, ch, c);
      push(s + k, 1, ch, TICK ? (c & ~p) : 1'b0);
      p = c;
    end
  endtask

  task automatic flat(input int ch, input int s, input int n);
    for (int k = 0; k < n; k++) begin
      push(s + k, 0, ch, 1'b0);
      push(s + k, 1, ch, 1'b0);
    end
  endtask

  task automatic rdy(input int s, input int n, input bit v);
    for (int k = 0; k < n; k++) push(s + k, 2, 0, v);
  endtask

  // Return just after the active edge number n.
  task automatic at(input int n);
    while (cyc < n) begin
      @(posedge clki);
      #1;
    end
  endtask

  always @(negedge clki) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].cyc <= cyc) begin
        logic act;
        string nm;
        case (sbq[i].kind)
          0:       begin act = clk_o[sbq[i].ch];  nm = "clk_o";     end
          1:       begin act = tick_o[sbq[i].ch]; nm = "tick_o";    end
          default: begin act = cfg_ready;         nm = "cfg_ready"; end
        endcase
        tests++;
        if (sbq[i].cyc != cyc || act !== sbq[i].val) begin
          fails++;
          $display("FAIL %s ch%0d cyc %0d (now %0d): got %b expected %b",
                   nm, sbq[i].ch, sbq[i].cyc, cyc, act, sbq[i].val);
        end
        sbq.delete(i);
      end
    end
  end

  initial begin
    // reset state
    for (int ch = 0; ch < N_CH; ch++) flat(ch, 1, 2);
    rdy(1, 2, 1'b1);
    at(2);
    rst = 1'b0;

    // ch0: default 10/5 from edge 6; ch1 reconfigured mid-period to 4/1,
    // then on a wrap cycle to 6/3 (one extra old period)
    wave(0, 6, 95, 10, 5, 1'b0);
    wave(1, 6, 10, 10, 5, 1'b0);
    wave(1, 16, 16, 4, 1, 1'b0);
    wave(1, 32, 69, 6, 3, 1'b0);
    rdy(7, 1, 1'b1);
    rdy(8, 8, 1'b0);
    rdy(16, 1, 1'b1);
    rdy(28, 4, 1'b0);
    rdy(32, 1, 1'b1);
    // ch2: idle config 8/4, stop from cnt=2, then drop/reassert before wrap
    flat(2, 3, 44);
    rdy(44, 1, 1'b0);
    rdy(45, 1, 1'b1);
    wave(2, 47, 8, 8, 4, 1'b0);
    flat(2, 55, 6);
    wave(2, 61, 40, 8, 4, 1'b0);
    // ch3: div 1/high 0 -> div 2 held low; then 6/9 -> held high, one tick
    flat(3, 3, 90);
    rdy(91, 2, 1'b0);
    rdy(93, 1, 1'b1);
    wave(3, 93, 8, 6, 6, 1'b0);
    // clk_enb pulse, restart with retained config, then async rst mid-high
    for (int ch = 0; ch < N_CH; ch++) flat(ch, 101, 1);
    wave(0, 102, 2, 10, 5, 1'b0);
    wave(1, 102, 2, 6, 3, 1'b0);
    wave(2, 102, 2, 8, 4, 1'b0);
    wave(3, 102, 2, 6, 6, 1'b0);
    for (int ch = 0; ch < N_CH; ch++) flat(ch, 104, 3);
    rdy(104, 1, 1'b1);
    for (int ch = 0; ch < N_CH; ch++) wave(ch, 107, 20, 10, 5, 1'b0);

    at(5);   ch_en = 4'b0011;
    at(7);   cfg_ch = 2'd1; cfg_div = 26'd4; cfg_high = 26'd1; cfg_valid = 1'b1;
    at(8);   cfg_valid = 1'b0;
    at(27);  cfg_div = 26'd6; cfg_high = 26'd3; cfg_valid = 1'b1;
    at(28);  cfg_valid = 1'b0;
    at(43);  cfg_ch = 2'd2; cfg_div = 26'd8; cfg_high = 26'd4; cfg_valid = 1'b1;
    at(44);  cfg_valid = 1'b0;
    at(46);  ch_en[2] = 1'b1;
    at(48);  ch_en[2] = 1'b0;
    at(60);  ch_en[2] = 1'b1;
    at(62);  ch_en[2] = 1'b0;
    at(65);  ch_en[2] = 1'b1;
    at(80);  cfg_ch = 2'd3; cfg_div = 26'd1; cfg_high = 26'd0; cfg_valid = 1'b1;
    at(81);  cfg_valid = 1'b0;
    at(82);  ch_en[3] = 1'b1;
    at(90);  cfg_div = 26'd6; cfg_high = 26'd9; cfg_valid = 1'b1;
    at(91);  cfg_valid = 1'b0;
    at(100); clk_enb = 1'b1;
    at(101); clk_enb = 1'b0;
    at(104); rst = 1'b1;
    at(106); rst = 1'b0;
    at(128);

    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
